comparator_seq: RTL

//   Parametrised multi-cycle magnitude comparator, successor to the 4-bit '85 cascade part.

---
 rtl/comparator_seq_pkg.sv | 33 +++
 rtl/comparator_slice.sv | 16 +
 rtl/comparator_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/comparator_seq_pkg.sv
// rtl/comparator_seq_pkg.sv - shared types and cascade resolution for the sequential comparator
package comparator_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  // '85-style resolution applied when every slice compared equal
  function automatic cmp_res_t cascade_resolve(input logic ilt, input logic ieq, input logic igt);
    cmp_res_t r;
    r = '0;
    if (ieq) begin
      r.eq = 1'b1;
    end else if (ilt && !igt) begin
      r.lt = 1'b1;
    end else if (igt && !ilt) begin
      r.gt = 1'b1;
    end else if (!ilt && !igt) begin
      r.lt = 1'b1;
      r.gt = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/comparator_slice.sv
// rtl/comparator_slice.sv - combinational unsigned compare of one slice
module comparator_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - multi-cycle magnitude comparator, one slice per clock, MSB slice first
module comparator_seq
  import comparator_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             ilt,
  input  logic             ieq,
  input  logic             igt,
  output logic             busy,
  output logic             done,
  output logic             olt,
  output logic             oeq,
  output logic             ogt
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(NS - 1);
  localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_l, b_l;
  logic             sm_l, ilt_l, ieq_l, igt_l;
  logic [IW-1:0]    idx;
  logic             decided, dec_lt, dec_gt;
  logic [SLICE-1:0] sa, sb;
  logic             s_lt, s_eq, s_gt;
  logic             accept, finish, differs, res_lt, res_gt;
  cmp_res_t         casc;

  // Operand registers shift left each RUN cycle so the slice under test is always on top
  assign sa = a_l[WIDTH-1 -: SLICE] ^ ((sm_l && idx == LAST_IDX) ? MSB_MASK : '0);
  assign sb = b_l[WIDTH-1 -: SLICE] ^ ((sm_l && idx == LAST_IDX) ? MSB_MASK : '0);

  comparator_slice #(.SLICE(SLICE)) u_slice (
    .a  (sa),
    .b  (sb),
    .lt (s_lt),
    .eq (s_eq),
    .gt (s_gt)
  );

  assign differs = decided | ~s_eq;
  assign res_lt  = decided ? dec_lt : s_lt;
  assign res_gt  = decided ? dec_gt : s_gt;
  assign casc    = cascade_resolve(ilt_l, ieq_l, igt_l);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        finish = (idx == '0) || ((EARLY_EXIT != 0) && !s_eq);
        if (finish) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      a_l     <= '0;
      b_l     <= '0;
      sm_l    <= 1'b0;
      ilt_l   <= 1'b0;
      ieq_l   <= 1'b0;
      igt_l   <= 1'b0;
      idx     <= '0;
      decided <= 1'b0;
      dec_lt  <= 1'b0;
      dec_gt  <= 1'b0;
      olt     <= 1'b0;
      oeq     <= 1'b0;
      ogt     <= 1'b0;
    end else if (accept) begin
      a_l     <= a;
      b_l     <= b;
      sm_l    <= signed_mode;
      ilt_l   <= ilt;
      ieq_l   <= ieq;
      igt_l   <= igt;
      idx     <= LAST_IDX;
      decided <= 1'b0;
      dec_lt  <= 1'b0;
      dec_gt  <= 1'b0;
    end else if (state == ST_RUN) begin
      if (finish) begin
        if (differs) begin
          olt <= res_lt;
          oeq <= 1'b0;
          ogt <= res_gt;
        end else begin
          olt <= casc.lt;
          oeq <= casc.eq;
          ogt <= casc.gt;
        end
      end else begin
        // Once a slice differs, the earlier (more significant) verdict is kept
        a_l     <= a_l << SLICE;
        b_l     <= b_l << SLICE;
        idx     <= idx - IW'(1);
        decided <= differs;
        dec_lt  <= res_lt;
        dec_gt  <= res_gt;
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
